// File: rtl/e_mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_ctrl_pkg
//  Purpose  : Shared definitions for the E-stage multiply/divide unit.
//             - mdu_* opcode constants, also used by the decoder and the
//               hazard unit.
//             - Default multiply/divide latencies.
//             - FSM state type.
//             - Helper that decides whether an opcode starts a busy window.
//  Config   : MDU_MAC_EN - when defined, madd/maddu/msub/msubu are legal
//             multi-cycle ops; otherwise they decode as unknown.
//  Revision : 1.0 - initial release
// ============================================================================
package e_mdu_ctrl_pkg;

    // MDU opcodes (4-bit). Codes 12..15 are unused and decode as unknown.
    localparam logic [3:0] c_mdu_mult  = 4'd0;
    localparam logic [3:0] c_mdu_multu = 4'd1;
    localparam logic [3:0] c_mdu_div   = 4'd2;
    localparam logic [3:0] c_mdu_divu  = 4'd3;
    localparam logic [3:0] c_mdu_madd  = 4'd4;
    localparam logic [3:0] c_mdu_maddu = 4'd5;
    localparam logic [3:0] c_mdu_msub  = 4'd6;
    localparam logic [3:0] c_mdu_msubu = 4'd7;
    localparam logic [3:0] c_mdu_mthi  = 4'd8;
    localparam logic [3:0] c_mdu_mtlo  = 4'd9;
    localparam logic [3:0] c_mdu_mfhi  = 4'd10;
    localparam logic [3:0] c_mdu_mflo  = 4'd11;

    // Default latencies (busy cycles).
    localparam int c_mult_cycles_def = 5;
    localparam int c_div_cycles_def  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for opcodes that open a busy window. The accumulate forms only
    // count when the MAC path is built.
    function automatic logic is_multi_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            c_mdu_mult, c_mdu_multu, c_mdu_div, c_mdu_divu: r = 1'b1;
`ifdef MDU_MAC_EN
            c_mdu_madd, c_mdu_maddu, c_mdu_msub, c_mdu_msubu: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == c_mdu_div) || (op == c_mdu_divu);
    endfunction

endpackage : e_mdu_ctrl_pkg
`default_nettype wire

// File: rtl/e_mdu_ctrl_arith.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_arith
//  Purpose  : Purely combinational MDU datapath. Computes the next {HI,LO}
//             from the latched operands, latched opcode and current HI/LO.
//  Ports    : i_op            latched opcode
//             i_a, i_b        latched rs / rt operands
//             i_hi, i_lo      current HI / LO
//             o_hi, o_lo      next HI / LO
//             o_we            1 when HI/LO must be written (0 on divide by
//                             zero and for non-arithmetic opcodes)
//  Config   : MDU_MAC_EN - builds the madd/maddu/msub/msubu accumulate path.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_arith
    import e_mdu_ctrl_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_we
);

    logic signed [63:0] w_a_sx;
    logic signed [63:0] w_b_sx;
    logic        [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic        [31:0] w_b_safe;
    logic        [31:0] w_quo_s;
    logic        [31:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;

    // Widen before multiplying so the full 64-bit product is kept.
    assign w_a_sx   = {{32{i_a[31]}}, i_a};
    assign w_b_sx   = {{32{i_b[31]}}, i_b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // The divider never sees a zero divisor; the result is discarded then.
    assign w_div_zero = (i_b == 32'd0);
    assign w_b_safe   = w_div_zero ? 32'd1 : i_b;
    // INT_MIN / -1 overflows the quotient; pin the architectural result.
    assign w_div_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Signed / and % truncate toward zero; remainder follows the dividend.
    assign w_quo_s = $signed(i_a) / $signed(w_b_safe);
    assign w_rem_s = $signed(i_a) % $signed(w_b_safe);
    assign w_quo_u = i_a / w_b_safe;
    assign w_rem_u = i_a % w_b_safe;

`ifdef MDU_MAC_EN
    logic [63:0] w_acc;
    assign w_acc = {i_hi, i_lo};
`endif

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        o_we = 1'b0;
        case (i_op)
            c_mdu_mult: begin
                {o_hi, o_lo} = w_prod_s;
                o_we         = 1'b1;
            end
            c_mdu_multu: begin
                {o_hi, o_lo} = w_prod_u;
                o_we         = 1'b1;
            end
            c_mdu_div: begin
                if (!w_div_zero) begin
                    o_lo = w_div_ovf ? 32'h8000_0000 : w_quo_s;
                    o_hi = w_div_ovf ? 32'd0         : w_rem_s;
                    o_we = 1'b1;
                end
            end
            c_mdu_divu: begin
                if (!w_div_zero) begin
                    o_lo = w_quo_u;
                    o_hi = w_rem_u;
                    o_we = 1'b1;
                end
            end
`ifdef MDU_MAC_EN
            c_mdu_madd: begin
                {o_hi, o_lo} = w_acc + w_prod_s;
                o_we         = 1'b1;
            end
            c_mdu_maddu: begin
                {o_hi, o_lo} = w_acc + w_prod_u;
                o_we         = 1'b1;
            end
            c_mdu_msub: begin
                {o_hi, o_lo} = w_acc - w_prod_s;
                o_we         = 1'b1;
            end
            c_mdu_msubu: begin
                {o_hi, o_lo} = w_acc - w_prod_u;
                o_we         = 1'b1;
            end
`endif
            default: begin
                o_we = 1'b0;
            end
        endcase
    end

endmodule : mdu_arith
`default_nettype wire

// File: rtl/e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_ctrl
//  Purpose  : E-stage multiply/divide sequencer. Latches operands on start,
//             holds busy for the fixed op latency, commits {HI,LO} on the
//             last busy edge and serves mfhi/mflo/mthi/mtlo.
//  Ports    : clk              rising-edge clock
//             reset_n          asynchronous active-low reset
//             start            E-stage multi-cycle MDU op (one-cycle pulse)
//             mdu_op[3:0]      mdu_* opcode
//             rs_e, rt_e[31:0] forwarded operands
//             busy             operation in flight
//             hi, lo[31:0]     architectural HI / LO
//             mdu_out[31:0]    HI for mfhi, LO for mflo, else 0 (comb.)
//  Config   : MDU_MAC_EN - enables madd/maddu/msub/msubu; when undefined
//             these opcodes are no-ops.
//  Revision : 1.0 - initial release
// ============================================================================
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = c_mult_cycles_def,
    parameter int DIV_CYCLES  = c_div_cycles_def
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    localparam int c_max_cycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;
    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES - 1);

    mdu_state_e         r_state;
    mdu_state_e         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_accept;
    logic               w_done;
    logic               w_mt_accept;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        w_lo_nxt;
    logic               w_arith_we;

    // mthi/mtlo are only honoured while idle and with no start pending, so
    // they can never collide with a commit or an op launch.
    assign w_accept    = (r_state == ST_IDLE) && start && is_multi_op(mdu_op);
    assign w_done      = (r_state == ST_RUN) && (r_cnt == '0);
    assign w_mt_accept = (r_state == ST_IDLE) && !start &&
                         ((mdu_op == c_mdu_mthi) || (mdu_op == c_mdu_mtlo));

    mdu_arith u_arith (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_hi_nxt),
        .o_lo (w_lo_nxt),
        .o_we (w_arith_we)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and busy.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counter and operand latches. Operands are captured only on the
    // accepting edge, so later rs_e/rt_e activity cannot disturb the op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_op  <= 4'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
        end else if (w_accept) begin
            r_cnt <= is_div_op(mdu_op) ? c_div_load : c_mult_load;
            r_op  <= mdu_op;
            r_a   <= rs_e;
            r_b   <= rt_e;
        end else if ((r_state == ST_RUN) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // HI/LO: committed on the final busy edge, or written by mthi/mtlo.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_done && w_arith_we) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end else if (w_mt_accept) begin
            if (mdu_op == c_mdu_mthi) begin
                r_hi <= rs_e;
            end else begin
                r_lo <= rs_e;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

    // Reads see the architectural registers, never an in-flight result.
    always_comb begin
        mdu_out = 32'd0;
        if (mdu_op == c_mdu_mfhi) begin
            mdu_out = r_hi;
        end else if (mdu_op == c_mdu_mflo) begin
            mdu_out = r_lo;
        end
    end

endmodule : e_mdu_ctrl
`default_nettype wire

// File: tb/tb_e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e_mdu_ctrl
//  Purpose  : Self-checking bench for e_mdu_ctrl. Each issued op pushes its
//             expected busy length and {HI,LO} onto a scoreboard queue; the
//             entry is popped and compared when busy drops.
//  Config   : MDU_MAC_EN - selects the accumulate expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    localparam int c_mult_n = 5;
    localparam int c_div_n  = 10;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [3:0]  mdu_op  = c_mdu_mflo;
    logic [31:0] rs_e    = 32'd0;
    logic [31:0] rt_e    = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];

    e_mdu_ctrl #(
        .MULT_CYCLES (c_mult_n),
        .DIV_CYCLES  (c_div_n)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .mdu_op  (mdu_op),
        .rs_e    (rs_e),
        .rt_e    (rt_e),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mdu_out (mdu_out)
    );

    always #5 clk = ~clk;

    // The hazard unit must never let start/mthi/mtlo reach a busy MDU.
    always @(posedge clk) begin
        if (reset_n && busy === 1'b1 &&
            (start || mdu_op == c_mdu_mthi || mdu_op == c_mdu_mtlo)) begin
            errors++;
            $display("FAIL protocol: start/mt issued while busy (op=%0d)", mdu_op);
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and check it through the scoreboard.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] ehi, input logic [31:0] elo,
                         input string name);
        exp_t e;
        int   cyc;
        e.hi = ehi;
        e.lo = elo;
        e.cycles = n;
        sb_q.push_back(e);
        start  = 1'b1;
        mdu_op = op;
        rs_e   = a;
        rt_e   = b;
        step();
        start  = 1'b0;
        mdu_op = c_mdu_mflo;
        rs_e   = $urandom;
        rt_e   = $urandom;
        cyc    = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            step();
        end
        e = sb_q.pop_front();
        checks++;
        if (cyc !== e.cycles) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, e.cycles);
        end
        checks++;
        if (hi !== e.hi) begin
            errors++;
            $display("FAIL %s hi: got %h expected %h", name, hi, e.hi);
        end
        checks++;
        if (lo !== e.lo) begin
            errors++;
            $display("FAIL %s lo: got %h expected %h", name, lo, e.lo);
        end
        mdu_op = c_mdu_mflo;
        #1;
        checks++;
        if (mdu_out !== e.lo) begin
            errors++;
            $display("FAIL %s mflo: got %h expected %h", name, mdu_out, e.lo);
        end
        mdu_op = c_mdu_mfhi;
        #1;
        checks++;
        if (mdu_out !== e.hi) begin
            errors++;
            $display("FAIL %s mfhi: got %h expected %h", name, mdu_out, e.hi);
        end
        mdu_op = c_mdu_mflo;
    endtask

    // mthi then mtlo; each value must be visible one cycle later.
    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        mdu_op = c_mdu_mthi;
        rs_e   = h;
        step();
        mdu_op = c_mdu_mtlo;
        rs_e   = l;
        checks++;
        if (hi !== h || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: got hi=%h busy=%b expected hi=%h busy=0", hi, busy, h);
        end
        step();
        mdu_op = c_mdu_mflo;
        checks++;
        if (lo !== l || hi !== h || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: got hi=%h lo=%h busy=%b expected hi=%h lo=%h busy=0",
                     hi, lo, busy, h, l);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        mdu_op = c_mdu_mfhi;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mdu_out !== 32'd0) begin
            errors++;
            $display("FAIL reset: got busy=%b hi=%h lo=%h out=%h expected 0/0/0/0",
                     busy, hi, lo, mdu_out);
        end
        mdu_op = c_mdu_mflo;
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_mult();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        do_op(c_mdu_mult, 32'hFFFF_FFFE, 32'd3, c_mult_n, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
        do_op(c_mdu_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_mult_n, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            do_op(c_mdu_mult, a, b, c_mult_n, p[63:32], p[31:0], "mult_rand");
        end
    endtask

    task automatic test_div();
        logic [31:0] a;
        logic [31:0] b;
        do_op(c_mdu_divu, 32'd7, 32'd2, c_div_n, 32'd1, 32'd3, "divu_7_2");
        do_op(c_mdu_div, 32'hFFFF_FFF9, 32'd2, c_div_n, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        do_op(c_mdu_div, 32'h8000_0000, 32'hFFFF_FFFF, c_div_n, 32'd0, 32'h8000_0000, "div_ovf");
        a = $urandom;
        b = $urandom_range(1, 1000);
        do_op(c_mdu_divu, a, b, c_div_n, a % b, a / b, "divu_rand");
    endtask

    task automatic test_div_zero();
        write_hilo(32'h11, 32'h22);
        do_op(c_mdu_div, 32'd5, 32'd0, c_div_n, 32'h11, 32'h22, "div_by_zero");
        do_op(c_mdu_divu, 32'd9, 32'd0, c_div_n, 32'h11, 32'h22, "divu_by_zero");
    endtask

    task automatic test_unknown_op();
        write_hilo(32'hDEAD_BEEF, 32'h1234_5678);
        do_op(4'hF, 32'd2, 32'd3, 0, 32'hDEAD_BEEF, 32'h1234_5678, "unknown_op");
        // mthi with start high is not an mt write and not a legal op.
        do_op(c_mdu_mthi, 32'hCAFE_F00D, 32'd0, 0, 32'hDEAD_BEEF, 32'h1234_5678, "mthi_with_start");
    endtask

    task automatic test_mac();
        write_hilo(32'd0, 32'd5);
`ifdef MDU_MAC_EN
        do_op(c_mdu_msubu, 32'd2, 32'd3, c_mult_n, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "msubu");
        do_op(c_mdu_madd, 32'hFFFF_FFFE, 32'd3, c_mult_n, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "madd");
`else
        do_op(c_mdu_msubu, 32'd2, 32'd3, 0, 32'd0, 32'd5, "msubu_disabled");
        do_op(c_mdu_madd, 32'hFFFF_FFFE, 32'd3, 0, 32'd0, 32'd5, "madd_disabled");
`endif
    endtask

    task automatic test_reset_mid_op();
        write_hilo(32'hAAAA_AAAA, 32'h5555_5555);
        start  = 1'b1;
        mdu_op = c_mdu_div;
        rs_e   = 32'd100;
        rt_e   = 32'd3;
        step();
        start  = 1'b0;
        mdu_op = c_mdu_mflo;
        step();
        step();
        // Now in busy cycle 3; assert reset away from the clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        do_op(c_mdu_mult, 32'd2, 32'd3, c_mult_n, 32'd0, 32'd6, "mult_after_reset");
    endtask

    task automatic test_back_to_back();
        do_op(c_mdu_mult, 32'd7, 32'd9, c_mult_n, 32'd0, 32'd63, "b2b_mult");
        do_op(c_mdu_multu, 32'hFFFF_FFFF, 32'd2, c_mult_n, 32'd1, 32'hFFFF_FFFE, "b2b_multu");
        do_op(c_mdu_divu, 32'd100, 32'd7, c_div_n, 32'd2, 32'd14, "b2b_divu");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_unknown_op();
        test_mac();
        test_reset_mid_op();
        test_back_to_back();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_e_mdu_ctrl
`default_nettype wire
